id_fwd_scoreboard: RTL
======================

# id_fwd_scoreboard

Parametrised ID-stage bypass controller that replaces per-stage destination comparators with a 32-entry register scoreboard. Each entry tracks the youngest in-flight producer of an architectural register: which stage it occupies and from which stage its result can be forwarded. For every ID source operand, the block produces a forwarding select and a load-use / long-latency stall. It sits in ID, beside the register file read, and drives the ID operand bypass muxes and the ID/EXE stall logic.

## Interface
- NSRC, 2, number of source operands looked up per ID instruction
- NSTAGE, 4, producer stages after ID (1=EXE, 2=MEM, 3=MEM2, 4=WB)
- FLUSH_AGE, 1, producers at age ≤ FLUSH_AGE are squashed by flush
- SELW, $clog2(NSTAGE+1), derived select width

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  instruction present in ID
- id_src  in  NSRC*5  source register numbers, operand i at [5i+4:5i]
- id_src_used  in  NSRC  operand i actually read
- id_wr  in  1  ID instruction writes a GPR
- id_dst  in  5  destination register
- id_rdy  in  SELW  stage whose output first holds the result (EXE ALU=1, load=2 or 3)
- be_adv  in  1  EXE..WB shift one stage this cycle
- flush  in  1  squash young producers
- fwd_sel  out  NSRC*SELW  0 = register file; k = forward from stage k result
- stall  out  1  ID must hold
- id_fire  out  1  ID instruction issues into EXE this edge
- stall_cnt  out  32  stall cycle counter (only with FWD_PERF_CNT_EN)

## Operation
- Entry r: valid, age[SELW-1:0], rdy[SELW-1:0]. Register 0 is never tracked.
- Per operand i, with entry e = sb[id_src[i]]:
  - If e.valid, e.age ≥ e.rdy and src_used: fwd_sel[i] = e.age.
  - Otherwise, fwd_sel[i] = 0.
  - hazard_i = src_used & e.valid & (e.age < e.rdy).
- stall = id_valid & |hazard.
- id_fire = id_valid & be_adv & ~stall & ~flush.
- Update order at each edge:
  1. flush: clear every valid entry with age ≤ FLUSH_AGE.
  2. be_adv: every surviving entry with age == NSTAGE clears (written to regfile); all others get age+1.
  3. id_fire & id_wr & id_dst≠0: sb[id_dst] ← {1, age=1, rdy=clamp(id_rdy)}. This overwrites any older producer.
- clamp: id_rdy of 0 or > NSTAGE becomes NSTAGE.
- Older producer of a register that was overwritten: it is not tracked further. The register file is still written in WB, and no younger reader depends on it.
- be_adv=0: ages hold and ID does not fire; outputs follow the held state.

## Timing
- fwd_sel and stall are combinational from registered scoreboard state plus ID inputs; there is no added latency.
- Issue at edge n gives age=1 visible at n+1.
- Back-to-back dependent ALU ops (rdy=1): the consumer sees sel=1, no stall.
- Load with rdy=2: consumer stalls exactly one be_adv cycle, then sees sel=2.
- Reset: all entries invalid, fwd_sel=0, stall=0, id_fire=0, stall_cnt=0.
- Reset mid-operation discards all tracking.
- flush + valid ID: no issue. flush + be_adv: flush is evaluated on pre-advance ages.
- Same-register issue and retire on one edge: the new entry wins.

## Configuration
- FWD_PERF_CNT_EN defined: stall_cnt increments on every cycle with stall=1 and be_adv=1, saturating at 32'hFFFF_FFFF.
- FWD_PERF_CNT_EN undefined: the stall_cnt port and counter logic are absent.

## Structure
- Shared package holds:
  - sb_entry_t struct {valid, age, rdy}
  - stage code constants FWD_RF=0, FWD_EXE=1, FWD_MEM=2, FWD_MEM2=3, FWD_WB=4
- Sub-module fwd_src_lookup: combinational per-operand lookup (entry in, src_used in, sel/hazard out), instantiated NSRC times by generate.

## Test plan
- addu r3 issued (rdy=1), next cycle ID reads rs=r3 -> fwd_sel[0]=1, stall=0; following cycle with be_adv -> sel=2.
- lw r5 (rdy=2), next ID reads rt=r5 -> stall=1 for one be_adv cycle, then fwd_sel[1]=2, id_fire=1.
- r7 producer at age 4 with be_adv=1 -> entry clears; next cycle sel=0 for reader of r7.
- Two writes to r9 one cycle apart -> reader sees sel=1 (youngest), not 2.
- flush with producers at ages 1 and 2, FLUSH_AGE=1 -> age-1 entry cleared, age-2 entry advances to 3; a valid ID instruction does not fire.
- be_adv=0 for 3 cycles during load hazard -> ages hold, stall stays 1, stall_cnt unchanged; the cycle be_adv resumes with stall=1, stall_cnt increments by 1.

Source files
------------

// File: rtl/id_fwd_scoreboard_pkg.sv
// Shared types and constants for the ID-stage forwarding scoreboard.
package id_fwd_scoreboard_pkg;

  localparam int unsigned SB_NSTAGE = 4;
  localparam int unsigned SB_SELW   = $clog2(SB_NSTAGE + 1);
  localparam int unsigned SB_NREG   = 32;
  localparam int unsigned SB_REGW   = 5;

  localparam logic [SB_SELW-1:0] FWD_RF   = SB_SELW'(0);
  localparam logic [SB_SELW-1:0] FWD_EXE  = SB_SELW'(1);
  localparam logic [SB_SELW-1:0] FWD_MEM  = SB_SELW'(2);
  localparam logic [SB_SELW-1:0] FWD_MEM2 = SB_SELW'(3);
  localparam logic [SB_SELW-1:0] FWD_WB   = SB_SELW'(4);

  typedef struct packed {
    logic               valid;
    logic [SB_SELW-1:0] age;
    logic [SB_SELW-1:0] rdy;
  } sb_entry_t;

  // Out-of-range ready stage means "only available from the last stage".
  function automatic logic [SB_SELW-1:0] clamp_rdy(input logic [SB_SELW-1:0] rdy,
                                                    input logic [SB_SELW-1:0] last);
    if (rdy == FWD_RF || rdy > last) return last;
    return rdy;
  endfunction

endpackage

// File: rtl/id_fwd_scoreboard_lookup.sv
// Per-operand scoreboard lookup: forwarding select and not-yet-ready hazard.
module fwd_src_lookup
  import id_fwd_scoreboard_pkg::*;
(
  input  sb_entry_t          ent_i,
  input  logic               used_i,
  output logic [SB_SELW-1:0] sel_o,
  output logic               hazard_o
);

  always_comb begin
    sel_o    = FWD_RF;
    hazard_o = 1'b0;
    if (used_i && ent_i.valid) begin
      if (ent_i.age >= ent_i.rdy) sel_o = ent_i.age;
      else                        hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// ID-stage bypass controller tracking the youngest in-flight producer per GPR.
// Optional stall cycle counter enabled by defining FWD_PERF_CNT_EN.
module id_fwd_scoreboard
  import id_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NSRC      = 2,
  parameter int unsigned NSTAGE    = SB_NSTAGE,
  parameter int unsigned FLUSH_AGE = 1,
  parameter int unsigned SELW      = $clog2(NSTAGE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NSRC*5-1:0]    id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic                 id_wr,
  input  logic [4:0]           id_dst,
  input  logic [SELW-1:0]      id_rdy,
  input  logic                 be_adv,
  input  logic                 flush,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 stall,
  output logic                 id_fire
`ifdef FWD_PERF_CNT_EN
  ,output logic [31:0]         stall_cnt
`endif
);

  localparam logic [SB_SELW-1:0] LAST_AGE  = SB_SELW'(NSTAGE);
  localparam logic [SB_SELW-1:0] FLUSH_LIM = SB_SELW'(FLUSH_AGE);

  sb_entry_t          sb_q [SB_NREG];
  sb_entry_t          sb_d [SB_NREG];
  logic [SB_SELW-1:0] sel_w [NSRC];
  logic [NSRC-1:0]    hazard;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_src_lookup u_lookup (
      .ent_i    (sb_q[id_src[i*5 +: 5]]),
      .used_i   (id_src_used[i]),
      .sel_o    (sel_w[i]),
      .hazard_o (hazard[i])
    );
    assign fwd_sel[i*SELW +: SELW] = SELW'(sel_w[i]);
  end

  assign stall   = id_valid & (|hazard);
  assign id_fire = id_valid & be_adv & ~stall & ~flush;

  // Flush on pre-advance ages, then advance/retire, then the new producer wins.
  always_comb begin
    sb_d = sb_q;
    for (int r = 1; r < 32; r++) begin
      if (flush && sb_d[r].valid && sb_d[r].age <= FLUSH_LIM) sb_d[r] = '0;
      if (be_adv && sb_d[r].valid) begin
        if (sb_d[r].age == LAST_AGE) sb_d[r] = '0;
        else                         sb_d[r].age = sb_d[r].age + SB_SELW'(1);
      end
    end
    if (id_fire && id_wr && id_dst != 5'd0) begin
      sb_d[id_dst].valid = 1'b1;
      sb_d[id_dst].age   = FWD_EXE;
      sb_d[id_dst].rdy   = clamp_rdy(SB_SELW'(id_rdy), LAST_AGE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '{default: '0};
    else     sb_q <= sb_d;
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && be_adv && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`endif

endmodule
